// File: rtl/dr_pkg.sv
// Shared types and dual-rail helpers for the
// synchronous controller of the dual-rail adder.
package dr_pkg;

  localparam int DR_MAXW = 32;

  localparam logic [DR_MAXW-1:0] DR_SPACER = '0;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_EVAL,
    ST_SPACER,
    ST_OUT,
    ST_RECOVER
  } dr_state_e;

  function automatic logic [2*DR_MAXW-1:0] dr_encode(
    input logic [DR_MAXW-1:0] value
  );
    return {value, ~value};
  endfunction

  // Only the low n bit pairs are checked.
  function automatic logic dr_code_ok(
    input logic [DR_MAXW-1:0] r1,
    input logic [DR_MAXW-1:0] r0,
    input int unsigned        n
  );
    logic [DR_MAXW-1:0] m;
    m = ~({DR_MAXW{1'b1}} << n);
    return &((r1 ^ r0) | ~m);
  endfunction

endpackage

// File: rtl/dr_sync_bit.sv
// N-stage single-bit synchronizer,
// asynchronous active-high reset.
module dr_sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/dr_adder_sync_ctrl.sv
// Valid/ready front end that runs one
// return-to-zero cycle of the dual-rail adder per op.
module dr_adder_sync_ctrl
  import dr_pkg::*;
#(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_sum,
  output logic         out_err,
  output logic [W-1:0] dr_a_1,
  output logic [W-1:0] dr_a_0,
  output logic [W-1:0] dr_b_1,
  output logic [W-1:0] dr_b_0,
  input  logic [W:0]   dr_s_1,
  input  logic [W:0]   dr_s_0,
  output logic         dr_go,
  input  logic         dr_done,
  output logic         dr_reset
);

  localparam int CW = $clog2(TIMEOUT + 1);

  function automatic logic [W-1:0] rail1(
    input logic [W-1:0] v
  );
    return W'(dr_encode(DR_MAXW'(v)) >> DR_MAXW);
  endfunction

  function automatic logic [W-1:0] rail0(
    input logic [W-1:0] v
  );
    return W'(dr_encode(DR_MAXW'(v)));
  endfunction

  dr_state_e      state_q, state_d;
  logic [W-1:0]   a1_q, a1_d, a0_q, a0_d;
  logic [W-1:0]   b1_q, b1_d, b0_q, b0_d;
  logic           go_q, go_d;
  logic [W:0]     sum_q, sum_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rec_q, rec_d;
  logic           abort_q, abort_d;
  logic           done_s;
  logic           timeout;

  dr_sync_bit #(
    .N (SYNC_STAGES)
  ) u_done_sync (
    .clk (clk),
    .rst (reset),
    .d_i (dr_done),
    .q_o (done_s)
  );

  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    a1_d    = a1_q;
    a0_d    = a0_q;
    b1_d    = b1_q;
    b0_d    = b0_q;
    go_d    = go_q;
    sum_d   = sum_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rec_d   = rec_q;
    abort_d = abort_q;
    if ((state_q == ST_EVAL || state_q == ST_SPACER)
        && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      ST_INIT: begin
        if (!done_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (in_valid) begin
          a1_d    = rail1(in_a);
          a0_d    = rail0(in_a);
          b1_d    = rail1(in_b);
          b0_d    = rail0(in_b);
          go_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // done_s has priority over a same-cycle timeout
        if (done_s) begin
          sum_d = dr_s_1;
          err_d = !dr_code_ok(DR_MAXW'(dr_s_1),
                              DR_MAXW'(dr_s_0),
                              W + 1);
          state_d = ST_SPACER;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = ST_RECOVER;
          rec_d   = 1'b0;
        end
        if (done_s || timeout) begin
          a1_d = W'(DR_SPACER);
          a0_d = W'(DR_SPACER);
          b1_d = W'(DR_SPACER);
          b0_d = W'(DR_SPACER);
          go_d = 1'b0;
        end
      end
      ST_SPACER: begin
        if (!done_s) begin
          state_d = ST_OUT;
        end else if (timeout) begin
          state_d = ST_RECOVER;
          rec_d   = 1'b0;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = abort_q ? ST_INIT : ST_IDLE;
          abort_d = 1'b0;
        end
      end
      ST_RECOVER: begin
        sum_d   = '0;
        err_d   = 1'b1;
        abort_d = 1'b1;
        rec_d   = 1'b1;
        if (rec_q) state_d = ST_OUT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      a1_q    <= '0;
      a0_q    <= '0;
      b1_q    <= '0;
      b0_q    <= '0;
      go_q    <= 1'b0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rec_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      b1_q    <= b1_d;
      b0_q    <= b0_d;
      go_q    <= go_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
      abort_q <= abort_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign out_sum   = sum_q;
  assign out_err   = err_q;
  assign dr_a_1    = a1_q;
  assign dr_a_0    = a0_q;
  assign dr_b_1    = b1_q;
  assign dr_b_0    = b0_q;
  assign dr_go     = go_q;
  // adder reset follows the system reset without a clock
  assign dr_reset  = reset | (state_q == ST_RECOVER);

endmodule

// File: tb/tb_dr_adder_sync_ctrl.sv
// Scoreboard bench for dr_adder_sync_ctrl with a
// behavioural dual-rail adder model.
module tb_dr_adder_sync_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:0]   out_sum;
  logic         out_err;
  logic [W-1:0] dr_a_1, dr_a_0, dr_b_1, dr_b_0;
  logic [W:0]   dr_s_1 = '0;
  logic [W:0]   dr_s_0 = '0;
  logic         dr_go;
  logic         dr_done = 1'b0;
  logic         dr_reset;

  int vec_n = 0;
  int miss_n = 0;
  int rst_cyc = 0;
  logic [W+1:0] sb[$];

  int m_mode = 0;
  int m_up = 3;
  int m_dn = 2;
  int m_cnt = 0;
  logic [W:0] m_sum;

  dr_adder_sync_ctrl u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_err   (out_err),
    .dr_a_1    (dr_a_1),
    .dr_a_0    (dr_a_0),
    .dr_b_1    (dr_b_1),
    .dr_b_0    (dr_b_0),
    .dr_s_1    (dr_s_1),
    .dr_s_0    (dr_s_0),
    .dr_go     (dr_go),
    .dr_done   (dr_done),
    .dr_reset  (dr_reset)
  );

  always #5 clk = ~clk;

  assign m_sum = dr_a_1 + dr_b_1;

  // mode 0 normal, 1 never completes, 2 bit 2 of both rails high
  always @(posedge clk or posedge dr_reset) begin
    if (dr_reset) begin
      dr_done <= 1'b0;
      dr_s_1  <= '0;
      dr_s_0  <= '0;
      m_cnt   <= 0;
    end else if (dr_go && !dr_done) begin
      if (m_mode != 1) begin
        if (m_cnt >= m_up - 1) begin
          dr_done <= 1'b1;
          m_cnt   <= 0;
          dr_s_1  <= (m_mode == 2) ? (m_sum | 5'b00100) : m_sum;
          dr_s_0  <= (m_mode == 2) ? (~m_sum | 5'b00100) : ~m_sum;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (!dr_go && dr_done) begin
      if (m_cnt >= m_dn - 1) begin
        dr_done <= 1'b0;
        dr_s_1  <= '0;
        dr_s_0  <= '0;
        m_cnt   <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      m_cnt <= 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec_n++;
    if (got !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input bit push,
                      input logic [W+1:0] exp);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    if (push) sb.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic take(input int hold, input bit abort);
    int n = 0;
    logic [W+1:0] e;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
      if (dr_reset) rst_cyc++;
    end
    chk("ov_wait", out_valid, 1);
    chk("sb_nonempty", sb.size() != 0, 1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    chk("sum", out_sum, e[W:0]);
    chk("err", out_err, e[W+1]);
    chk("rdy_in_out", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_ov", out_valid, 1);
      chk("bp_sum", out_sum, e[W:0]);
      chk("bp_err", out_err, e[W+1]);
      chk("bp_rdy", in_ready, 0);
      chk("bp_go", dr_go, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("ov_drop", out_valid, 0);
    chk("rdy_after", in_ready, !abort);
    if (abort) begin
      @(negedge clk);
      chk("rdy_after_init", in_ready, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ov_n;
    repeat (3) @(negedge clk);
    chk("rst_rdy", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_err", out_err, 0);
    chk("rst_rails", {dr_a_1, dr_a_0, dr_b_1, dr_b_0}, 0);
    chk("rst_go", dr_go, 0);
    chk("rst_drst", dr_reset, 1);
    reset = 1'b0;

    send(4'd5, 4'd9, 1'b1, {1'b0, 5'b01110});
    chk("eval_a1", dr_a_1, 4'b0101);
    chk("eval_a0", dr_a_0, 4'b1010);
    chk("eval_b1", dr_b_1, 4'b1001);
    chk("eval_b0", dr_b_0, 4'b0110);
    chk("eval_go", dr_go, 1);
    n = 0;
    while (dr_go && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("spc_go", dr_go, 0);
    chk("spc_rails", {dr_a_1, dr_a_0, dr_b_1, dr_b_0}, 0);
    chk("spc_ov", out_valid, 0);
    take(0, 1'b0);

    send(4'd15, 4'd15, 1'b1, {1'b0, 5'd30});
    take(0, 1'b0);
    send(4'd0, 4'd0, 1'b1, {1'b0, 5'd0});
    take(0, 1'b0);

    out_ready = 1'b0;
    send(4'd7, 4'd3, 1'b1, {1'b0, 5'd10});
    take(10, 1'b0);

    m_mode = 1;
    rst_cyc = 0;
    send(4'd3, 4'd4, 1'b1, {1'b1, 5'd0});
    take(0, 1'b1);
    chk("rec_len", rst_cyc, 2);

    m_mode = 2;
    send(4'd1, 4'd2, 1'b1, {1'b1, 5'd7});
    take(0, 1'b0);

    m_mode = 0;
    m_up = 10;
    send(4'd2, 4'd2, 1'b0, '0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("ar_rails", {dr_a_1, dr_a_0, dr_b_1, dr_b_0}, 0);
    chk("ar_go", dr_go, 0);
    chk("ar_drst", dr_reset, 1);
    @(negedge clk);
    reset = 1'b0;
    chk("ar_init", in_ready, 0);
    ov_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) ov_n++;
    end
    chk("ar_spur_ov", ov_n, 0);
    chk("ar_idle", in_ready, 1);
    chk("ar_sb", sb.size(), 0);

    m_up = 3;
    send(4'd6, 4'd7, 1'b1, {1'b0, 5'd13});
    take(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, miss_n);
    $finish;
  end

endmodule
